// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared FSM state type and parameter defaults for the SDRAM port arbiter
package sdram_arb_pkg;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 26;
    localparam int DEF_BL_WIDTH   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting after the last grant
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int IW     = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IW-1:0]     last_grant,
    output logic              valid,
    output logic [IW-1:0]     idx
);

    // Scan from the farthest candidate back to the nearest so the nearest
    // requester after last_grant is the final (winning) assignment.
    always_comb begin
        int c;
        valid = 1'b0;
        idx   = '0;
        c     = 0;
        for (int i = NUM_CH; i >= 1; i--) begin
            c = int'(last_grant) + i;
            if (c >= NUM_CH) begin
                c = c - NUM_CH;
            end
            if (req[c]) begin
                valid = 1'b1;
                idx   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin multi-channel front end for a single SDRAM controller port
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BL_WIDTH   = DEF_BL_WIDTH
) (
    input  logic                                 sys_clk,
    input  logic                                 reset,
    input  logic [NUM_CH-1:0]                    ch_req,
    input  logic [NUM_CH-1:0]                    ch_wr_n,
    input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    ch_addr,
    input  logic [NUM_CH-1:0][BL_WIDTH-1:0]      ch_len,
    output logic [NUM_CH-1:0]                    ch_ack,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    ch_wr_data,
    output logic [NUM_CH-1:0]                    ch_wr_next,
    output logic [NUM_CH-1:0]                    ch_rd_valid,
    output logic [DATA_WIDTH-1:0]                ch_rd_data,
    output logic                                 app_req,
    output logic                                 app_req_wr_n,
    output logic [ADDR_WIDTH-1:0]                app_req_addr,
    output logic [BL_WIDTH-1:0]                  app_req_len,
    output logic [DATA_WIDTH-1:0]                app_wr_data,
    input  logic                                 app_req_ack,
    input  logic                                 app_wr_next,
    input  logic                                 app_rd_valid,
    input  logic [DATA_WIDTH-1:0]                app_rd_data
);

    localparam int IW = $clog2(NUM_CH);

    arb_state_e            state_q, state_d;
    logic [IW-1:0]         grant_q, grant_d;
    logic [IW-1:0]         last_q, last_d;
    logic [BL_WIDTH-1:0]   cnt_q, cnt_d;
    logic                  app_req_q, app_req_d;
    logic                  wr_n_q, wr_n_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BL_WIDTH-1:0]   len_q, len_d;

    logic                  pick_valid;
    logic [IW-1:0]         pick_idx;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IW     (IW)
    ) u_rr_pick (
        .req        (ch_req),
        .last_grant (last_q),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    // Next-state logic: grant, hold the request, then count beats of the burst.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        app_req_d = app_req_q;
        wr_n_d    = wr_n_q;
        addr_d    = addr_q;
        len_d     = len_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d   = pick_idx;
                    addr_d    = ch_addr[pick_idx];
                    len_d     = ch_len[pick_idx];
                    wr_n_d    = ch_wr_n[pick_idx];
                    app_req_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (app_req_ack) begin
                    app_req_d = 1'b0;
                    // A zero length still moves one beat.
                    cnt_d     = (len_q == '0) ? BL_WIDTH'(1) : len_q;
                    state_d   = wr_n_q ? ST_RDATA : ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (app_wr_next) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == BL_WIDTH'(1)) begin
                        last_d  = grant_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RDATA: begin
                if (app_rd_valid) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == BL_WIDTH'(1)) begin
                        last_d  = grant_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; last_grant resets to the top channel so channel 0 wins first.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= IW'(NUM_CH - 1);
            cnt_q     <= '0;
            app_req_q <= 1'b0;
            wr_n_q    <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            app_req_q <= app_req_d;
            wr_n_q    <= wr_n_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
        end
    end

    // Steer strobes and data between the controller and the granted channel only.
    always_comb begin
        ch_ack      = '0;
        ch_wr_next  = '0;
        ch_rd_valid = '0;
        ch_rd_data  = '0;
        app_wr_data = '0;
        case (state_q)
            ST_REQ: begin
                ch_ack[grant_q] = app_req_ack;
            end
            ST_WDATA: begin
                app_wr_data         = ch_wr_data[grant_q];
                ch_wr_next[grant_q] = app_wr_next;
            end
            ST_RDATA: begin
                ch_rd_valid[grant_q] = app_rd_valid;
                ch_rd_data           = app_rd_data;
            end
            default: ;
        endcase
    end

    assign app_req      = app_req_q;
    assign app_req_wr_n = wr_n_q;
    assign app_req_addr = addr_q;
    assign app_req_len  = len_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - scoreboard bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

    localparam int NC = 4;
    localparam int DW = 16;
    localparam int AW = 26;
    localparam int BW = 8;

    logic                      sys_clk = 1'b0;
    logic                      reset;
    logic [NC-1:0]             ch_req;
    logic [NC-1:0]             ch_wr_n;
    logic [NC-1:0][AW-1:0]     ch_addr;
    logic [NC-1:0][BW-1:0]     ch_len;
    logic [NC-1:0]             ch_ack;
    logic [NC-1:0][DW-1:0]     ch_wr_data;
    logic [NC-1:0]             ch_wr_next;
    logic [NC-1:0]             ch_rd_valid;
    logic [DW-1:0]             ch_rd_data;
    logic                      app_req;
    logic                      app_req_wr_n;
    logic [AW-1:0]             app_req_addr;
    logic [BW-1:0]             app_req_len;
    logic [DW-1:0]             app_wr_data;
    logic                      app_req_ack;
    logic                      app_wr_next;
    logic                      app_rd_valid;
    logic [DW-1:0]             app_rd_data;

    sdram_port_arbiter #(
        .NUM_CH     (NC),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BL_WIDTH   (BW)
    ) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .ch_req       (ch_req),
        .ch_wr_n      (ch_wr_n),
        .ch_addr      (ch_addr),
        .ch_len       (ch_len),
        .ch_ack       (ch_ack),
        .ch_wr_data   (ch_wr_data),
        .ch_wr_next   (ch_wr_next),
        .ch_rd_valid  (ch_rd_valid),
        .ch_rd_data   (ch_rd_data),
        .app_req      (app_req),
        .app_req_wr_n (app_req_wr_n),
        .app_req_addr (app_req_addr),
        .app_req_len  (app_req_len),
        .app_wr_data  (app_wr_data),
        .app_req_ack  (app_req_ack),
        .app_wr_next  (app_wr_next),
        .app_rd_valid (app_rd_valid),
        .app_rd_data  (app_rd_data)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int            ch;
        logic          wr_n;
        logic [AW-1:0] addr;
        logic [BW-1:0] len;
    } grant_t;

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
    } beat_t;

    grant_t exp_grant[$];
    beat_t  exp_wr[$];
    beat_t  exp_rd[$];

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [NC-1:0] v);
        int r = -1;
        for (int i = 0; i < NC; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] wr_pattern(input int c, input int b);
        return DW'(16'h1000 * (c + 1) + b);
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents an ack or a beat strobe.
    always @(negedge sys_clk) begin
        if (mon_en) begin
            if (ch_ack != '0) begin
                chk("ack_onehot", 64'($countones(ch_ack)), 64'd1);
                if (exp_grant.size() == 0) begin
                    chk("unexpected_ack", 64'(ch_ack), 64'd0);
                end else begin
                    grant_t g;
                    g = exp_grant.pop_front();
                    chk("grant_ch", 64'(onehot_idx(ch_ack)), 64'(g.ch));
                    chk("grant_addr", 64'(app_req_addr), 64'(g.addr));
                    chk("grant_len", 64'(app_req_len), 64'(g.len));
                    chk("grant_wr_n", 64'(app_req_wr_n), 64'(g.wr_n));
                end
            end
            if (ch_wr_next != '0) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_wr_next", 64'(ch_wr_next), 64'd0);
                end else begin
                    beat_t e;
                    e = exp_wr.pop_front();
                    chk("wr_next_ch", 64'(ch_wr_next), 64'(1 << e.ch));
                    chk("wr_data", 64'(app_wr_data), 64'(e.data));
                end
            end
            if (ch_rd_valid != '0) begin
                if (exp_rd.size() == 0) begin
                    chk("unexpected_rd_valid", 64'(ch_rd_valid), 64'd0);
                end else begin
                    beat_t e;
                    e = exp_rd.pop_front();
                    chk("rd_valid_ch", 64'(ch_rd_valid), 64'(1 << e.ch));
                    chk("rd_data", 64'(ch_rd_data), 64'(e.data));
                end
            end
        end
    end

    // Controller model: wait for app_req, hold off the ack, then move the beats.
    task automatic serve(input int ch, input int delay, input int nbeats, input logic rd,
                         input logic [DW-1:0] base, input bit gap, input bit clear_req,
                         output int waited);
        int n = 0;
        logic [AW-1:0] a0;
        logic [BW-1:0] l0;
        while (!app_req && n < 50) begin
            @(posedge sys_clk); #1;
            n++;
        end
        waited = n;
        if (!app_req) begin
            chk("app_req_timeout", 64'd0, 64'd1);
            return;
        end
        a0 = app_req_addr;
        l0 = app_req_len;
        for (int d = 0; d < delay; d++) begin
            @(posedge sys_clk); #1;
            chk("req_hold", 64'(app_req), 64'd1);
            chk("addr_hold", 64'(app_req_addr), 64'(a0));
            chk("len_hold", 64'(app_req_len), 64'(l0));
            chk("no_early_ack", 64'(ch_ack), 64'd0);
        end
        app_req_ack = 1'b1;
        @(posedge sys_clk); #1;
        app_req_ack = 1'b0;
        chk("req_dropped", 64'(app_req), 64'd0);
        if (clear_req) ch_req = '0;
        for (int b = 0; b < nbeats; b++) begin
            if (gap && b == 1) begin
                @(posedge sys_clk); #1;
            end
            if (rd) begin
                app_rd_valid = 1'b1;
                app_rd_data  = base + DW'(b);
                exp_rd.push_back('{ch, base + DW'(b)});
            end else begin
                for (int c = 0; c < NC; c++) ch_wr_data[c] = wr_pattern(c, b);
                app_wr_next = 1'b1;
                exp_wr.push_back('{ch, wr_pattern(ch, b)});
            end
            @(posedge sys_clk); #1;
            app_rd_valid = 1'b0;
            app_wr_next  = 1'b0;
        end
    endtask

    task automatic set_ch(input int c, input logic wr_n, input logic [AW-1:0] a, input logic [BW-1:0] l);
        ch_wr_n[c] = wr_n;
        ch_addr[c] = a;
        ch_len[c]  = l;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset        = 1'b1;
        ch_req       = '0;
        ch_wr_n      = '0;
        ch_addr      = '0;
        ch_len       = '0;
        ch_wr_data   = '0;
        app_req_ack  = 1'b0;
        app_wr_next  = 1'b0;
        app_rd_valid = 1'b0;
        app_rd_data  = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        mon_en = 1'b1;
        chk("rst_app_req", 64'(app_req), 64'd0);
        chk("rst_ch_ack", 64'(ch_ack), 64'd0);
        chk("rst_wr_next", 64'(ch_wr_next), 64'd0);
        chk("rst_rd_valid", 64'(ch_rd_valid), 64'd0);
        chk("rst_addr", 64'(app_req_addr), 64'd0);
        chk("rst_wr_data", 64'(app_wr_data), 64'd0);
        reset = 1'b0;

        // All four channels write len=2: grants 0,1,2,3,0 with one idle cycle between.
        for (int c = 0; c < NC; c++) set_ch(c, 1'b0, AW'(16 * c), 8'd2);
        exp_grant.push_back('{0, 1'b0, 26'h00, 8'd2});
        exp_grant.push_back('{1, 1'b0, 26'h10, 8'd2});
        exp_grant.push_back('{2, 1'b0, 26'h20, 8'd2});
        exp_grant.push_back('{3, 1'b0, 26'h30, 8'd2});
        exp_grant.push_back('{0, 1'b0, 26'h00, 8'd2});
        ch_req = 4'b1111;
        serve(0, 0, 2, 1'b0, '0, 1'b0, 1'b0, w);
        serve(1, 0, 2, 1'b0, '0, 1'b0, 1'b0, w);
        chk("idle_gap_1", 64'(w), 64'd1);
        serve(2, 0, 2, 1'b0, '0, 1'b0, 1'b0, w);
        chk("idle_gap_2", 64'(w), 64'd1);
        serve(3, 0, 2, 1'b0, '0, 1'b0, 1'b0, w);
        chk("idle_gap_3", 64'(w), 64'd1);
        serve(0, 0, 2, 1'b0, '0, 1'b0, 1'b1, w);
        chk("idle_gap_4", 64'(w), 64'd1);
        chk("s1_back_idle", 64'(app_req), 64'd0);

        // ch2 read of 4 beats with a stall; its request drops right after the ack.
        set_ch(2, 1'b1, 26'h100, 8'd4);
        exp_grant.push_back('{2, 1'b1, 26'h100, 8'd4});
        ch_req = 4'b0100;
        serve(2, 0, 4, 1'b1, 16'h00A0, 1'b1, 1'b1, w);
        chk("s2_back_idle", 64'(app_req), 64'd0);

        // ch1 write with len 0 moves exactly one beat; stray strobes in IDLE are ignored.
        set_ch(1, 1'b0, 26'h80, 8'd0);
        exp_grant.push_back('{1, 1'b0, 26'h80, 8'd0});
        ch_req = 4'b0010;
        serve(1, 0, 1, 1'b0, '0, 1'b0, 1'b1, w);
        chk("s3_back_idle", 64'(app_req), 64'd0);
        app_wr_next  = 1'b1;
        app_rd_valid = 1'b1;
        repeat (2) begin
            @(posedge sys_clk); #1;
            chk("s3_no_wr_next", 64'(ch_wr_next), 64'd0);
            chk("s3_no_rd_valid", 64'(ch_rd_valid), 64'd0);
            chk("s3_no_req", 64'(app_req), 64'd0);
        end
        app_wr_next  = 1'b0;
        app_rd_valid = 1'b0;

        // ch3 read whose ack arrives five cycles late.
        set_ch(3, 1'b1, 26'h2ABCDEF, 8'd1);
        exp_grant.push_back('{3, 1'b1, 26'h2ABCDEF, 8'd1});
        ch_req = 4'b1000;
        serve(3, 5, 1, 1'b1, 16'h5A5A, 1'b0, 1'b1, w);

        // Reset during beat 2 of a len=8 write on ch2, then channel 0 wins next.
        set_ch(2, 1'b0, 26'h400, 8'd8);
        exp_grant.push_back('{2, 1'b0, 26'h400, 8'd8});
        ch_req = 4'b0100;
        serve(2, 0, 1, 1'b0, '0, 1'b0, 1'b1, w);
        for (int c = 0; c < NC; c++) ch_wr_data[c] = wr_pattern(c, 1);
        app_wr_next = 1'b1;
        exp_wr.push_back('{2, wr_pattern(2, 1)});
        reset = 1'b1;
        set_ch(0, 1'b0, 26'h500, 8'd1);
        ch_req = 4'b0111;
        @(posedge sys_clk); #1;
        chk("s5_req_zero", 64'(app_req), 64'd0);
        chk("s5_wr_next_zero", 64'(ch_wr_next), 64'd0);
        chk("s5_wr_data_zero", 64'(app_wr_data), 64'd0);
        chk("s5_ack_zero", 64'(ch_ack), 64'd0);
        chk("s5_rd_valid_zero", 64'(ch_rd_valid), 64'd0);
        reset       = 1'b0;
        app_wr_next = 1'b0;
        exp_grant.push_back('{0, 1'b0, 26'h500, 8'd1});
        serve(0, 0, 1, 1'b0, '0, 1'b0, 1'b1, w);

        // ch1 and ch3 both hold requests: grants must alternate 1,3,1,3.
        set_ch(1, 1'b1, 26'h200, 8'd1);
        set_ch(3, 1'b1, 26'h300, 8'd1);
        exp_grant.push_back('{1, 1'b1, 26'h200, 8'd1});
        exp_grant.push_back('{3, 1'b1, 26'h300, 8'd1});
        exp_grant.push_back('{1, 1'b1, 26'h200, 8'd1});
        exp_grant.push_back('{3, 1'b1, 26'h300, 8'd1});
        ch_req = 4'b1010;
        serve(1, 0, 1, 1'b1, 16'h0B10, 1'b0, 1'b0, w);
        serve(3, 0, 1, 1'b1, 16'h0B30, 1'b0, 1'b0, w);
        serve(1, 0, 1, 1'b1, 16'h0B11, 1'b0, 1'b0, w);
        serve(3, 0, 1, 1'b1, 16'h0B31, 1'b0, 1'b1, w);

        repeat (4) @(posedge sys_clk);
        #1;
        chk("end_idle", 64'(app_req), 64'd0);
        chk("grants_left", 64'(exp_grant.size()), 64'd0);
        chk("wr_beats_left", 64'(exp_wr.size()), 64'd0);
        chk("rd_beats_left", 64'(exp_rd.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of requesting channels (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, SDRAM data width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 26, request address width in bits.
REQ-004 SHALL have parameter BL_WIDTH, default 8, burst-length field width in bits.
REQ-005 SHALL have one clock and a synchronous, active-high reset: port sys_clk, input, 1, rising-edge clock for all logic.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports ch_req/ch_wr_n, input, NUM_CH each: per-channel request and direction (1 = read).
REQ-008 SHALL have ports ch_addr/ch_len, input, NUM_CH x ADDR_WIDTH and NUM_CH x BL_WIDTH: per-channel address and beat count.
REQ-009 SHALL have port ch_ack, output, NUM_CH: one-cycle acceptance pulse.
REQ-010 SHALL have ports ch_wr_data, input, NUM_CH x DATA_WIDTH, and ch_wr_next, output, NUM_CH: write beat data and consume strobe.
REQ-011 SHALL have ports ch_rd_valid, output, NUM_CH, and ch_rd_data, output, DATA_WIDTH: read beat strobe and broadcast data.
REQ-012 SHALL have controller-side ports app_req, app_req_wr_n, app_req_addr, app_req_len, app_wr_data (outputs) and app_req_ack, app_wr_next, app_rd_valid, app_rd_data (inputs), with widths matching the channel side.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, WDATA, RDATA.
REQ-014 IDLE: when any ch_req is high, SHALL grant round-robin, searching from (last_grant+1) mod NUM_CH, latch addr/len/wr_n of the winner, and enter REQ the next cycle.
REQ-015 REQ: SHALL hold app_req=1 with the latched fields stable until app_req_ack=1.
REQ-016 On the app_req_ack cycle, SHALL pulse ch_ack[grant] for exactly one cycle, load beat counter = len, and enter WDATA (wr_n=0) or RDATA (wr_n=1).
REQ-017 A len of 0 SHALL be treated as 1 beat.
REQ-018 WDATA: app_wr_data SHALL equal ch_wr_data[grant] combinationally; ch_wr_next[grant] SHALL equal app_wr_next; counter SHALL decrement per app_wr_next.
REQ-019 RDATA: ch_rd_valid[grant] SHALL equal app_rd_valid; ch_rd_data SHALL equal app_rd_data; counter SHALL decrement per app_rd_valid.
REQ-020 On the last beat, SHALL update last_grant = grant and return to IDLE; back-to-back grants therefore incur exactly one IDLE cycle.
REQ-021 Non-granted channels SHALL see ch_ack, ch_wr_next and ch_rd_valid held at 0.
REQ-022 app_wr_next or app_rd_valid outside WDATA/RDATA respectively SHALL be ignored.
REQ-023 Deassertion of ch_req[grant] after grant SHALL NOT abort the transaction.
REQ-024 A channel whose ch_req is still high after its own completion SHALL NOT be re-granted while another channel requests.

Reset
REQ-025 On reset, SHALL enter IDLE, set last_grant = NUM_CH-1 (channel 0 wins first), clear the counter, and drive all outputs to 0.
REQ-026 Reset asserted mid-burst SHALL abandon the transaction with no further strobes from the next cycle.

Structure
REQ-027 Package sdram_arb_pkg SHALL hold the FSM state enum and parameter defaults.
REQ-028 Sub-module rr_pick SHALL compute the round-robin winner from the request vector and last_grant, combinationally.

Verification
REQ-029 Scenario: reset, then ch_req=4'b1111 all writes len=2 -> grants 0,1,2,3,0 in order; each ch_ack one cycle.
REQ-030 Scenario: ch2 read addr=0x100 len=4, app_rd_valid four beats 0xA0..0xA3 -> ch_rd_valid[2] four pulses with matching data, others 0.
REQ-031 Scenario: write len=0 on ch1 -> exactly one ch_wr_next[1] pulse, then IDLE.
REQ-032 Scenario: app_req_ack delayed 5 cycles -> app_req and latched fields stable all 5 cycles; no ch_ack early.
REQ-033 Scenario: reset asserted during beat 2 of a len=8 write -> next cycle IDLE, all outputs 0, next grant to channel 0.
REQ-034 Scenario: ch3 holds req continuously with ch1 -> alternating 1,3,1,3 grants, never 3 twice in a row.
